// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported synchronous memory between the
// fetch (IF) and load/store (D) ports, with one outstanding read and a stall counter.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_AW  = 14,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       stall_cnt
);

    if (MEM_LAT < 1 || MEM_LAT > 4) begin : gBadLatency
        $fatal(1, "mem_port_arbiter: MEM_LAT must be within 1..4");
    end

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arbStateT;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    arbStateT          state;
    logic [2:0]        latCnt;
    logic              ownerIsD;
    logic              lastGntIsD;
    logic [15:0]       stallCnt;
    logic [DATA_W-1:0] ifRdataHold;
    logic [DATA_W-1:0] dRdataHold;
    logic              accepting;
    logic              returning;
    logic              grantIf;
    logic              grantD;
    logic              stallNow;
    logic              unusedAddrBits;

    // Accept window: idle, or the return cycle of the outstanding read; reset blanks everything.
    always_comb begin
        accepting = 1'b0;
        returning = 1'b0;
        if (reset) begin
            accepting = 1'b0;
            returning = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    accepting = 1'b1;
                end
                RD_WAIT: begin
                    returning = (latCnt == 3'd1);
                    accepting = (latCnt == 3'd1);
                end
                default: begin
                    accepting = 1'b0;
                    returning = 1'b0;
                end
            endcase
        end
    end

    // Round-robin grant decode: on contention the port that did not win last time wins.
    always_comb begin
        grantIf = 1'b0;
        grantD  = 1'b0;
        if (accepting) begin
            if (if_req && d_req) begin
                grantD  = ~lastGntIsD;
                grantIf = lastGntIsD;
            end else begin
                grantD  = d_req;
                grantIf = if_req;
            end
        end else begin
            grantIf = 1'b0;
            grantD  = 1'b0;
        end
    end

    // Word index of the granted request; zero when nothing is granted.
    always_comb begin
        mem_addr = {MEM_AW{1'b0}};
        if (grantD) begin
            mem_addr = d_addr[MEM_AW+1:2];
        end else if (grantIf) begin
            mem_addr = if_addr[MEM_AW+1:2];
        end else begin
            mem_addr = {MEM_AW{1'b0}};
        end
    end

    assign if_gnt         = grantIf;
    assign d_gnt          = grantD;
    assign mem_en         = grantIf | grantD;
    assign mem_we         = grantD & d_we;
    assign mem_wdata      = (grantD && d_we) ? d_wdata : {DATA_W{1'b0}};
    assign if_rvalid      = returning & ~ownerIsD;
    assign d_rvalid       = returning & ownerIsD;
    assign if_rdata       = if_rvalid ? mem_rdata : ifRdataHold;
    assign d_rdata        = d_rvalid ? mem_rdata : dRdataHold;
    assign stall_cnt      = stallCnt;
    assign stallNow       = (if_req & ~grantIf) | (d_req & ~grantD);
    assign unusedAddrBits = ^{if_addr, d_addr};

    // Sequencer, priority pointer, returned-data holds and saturating stall counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            latCnt      <= 3'd0;
            ownerIsD    <= 1'b0;
            lastGntIsD  <= 1'b0;
            stallCnt    <= 16'd0;
            ifRdataHold <= {DATA_W{1'b0}};
            dRdataHold  <= {DATA_W{1'b0}};
        end else begin
            if (if_rvalid) begin
                ifRdataHold <= mem_rdata;
            end
            if (d_rvalid) begin
                dRdataHold <= mem_rdata;
            end
            if (stallNow && (stallCnt != 16'hFFFF)) begin
                stallCnt <= stallCnt + 16'd1;
            end
            if (grantIf || grantD) begin
                lastGntIsD <= grantD;
            end
            // A read (fetch or load) opens a new latency window; stores complete at once.
            if (grantIf || (grantD && !d_we)) begin
                state    <= RD_WAIT;
                latCnt   <= LAT_INIT;
                ownerIsD <= grantD;
            end else begin
                case (state)
                    RD_WAIT: begin
                        if (latCnt > 3'd1) begin
                            latCnt <= latCnt - 3'd1;
                        end else begin
                            state  <= IDLE;
                            latCnt <= 3'd0;
                        end
                    end
                    IDLE: begin
                        state  <= IDLE;
                        latCnt <= 3'd0;
                    end
                    default: begin
                        state  <= IDLE;
                        latCnt <= 3'd0;
                    end
                endcase
            end
        end
    end

endmodule
